// File: rtl/alu_issue.sv
// alu_issue: execute-stage sequencer in front of a combinational RV32I ALU.
// Decodes one instruction per transaction into an ALU control code and
// operands, captures the ALU result one cycle later, and presents a writeback
// result or a branch decision downstream.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid / in_ready             upstream handshake (in_ready high only in IDLE)
//   opcode, funct3, funct7_5        decoded instruction fields
//   rs1_val, rs2_val, imm, pc       operand sources (imm already sign-extended)
//   alu_a, alu_b, alu_ctrl          registered ALU inputs
//   alu_out, alu_is_zero            ALU result and zero flag
//   out_valid / out_ready           downstream handshake (out_valid high only in DONE)
//   out_result, out_is_branch,
//   out_branch_taken, out_illegal   captured transaction results
module alu_issue #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_is_zero,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_is_branch,
    output logic            out_branch_taken,
    output logic            out_illegal
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] alu_a_q, alu_a_d;
    logic [XLEN-1:0] alu_b_q, alu_b_d;
    logic [3:0]      alu_ctrl_q, alu_ctrl_d;
    // Branch qualifiers: use zero flag (BEQ/BNE) vs alu_out[0], and invert.
    logic            br_q, br_d;
    logic            br_zero_q, br_zero_d;
    logic            br_inv_q, br_inv_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_result_q, out_result_d;
    logic            out_is_branch_q, out_is_branch_d;
    logic            out_taken_q, out_taken_d;
    logic            out_illegal_q, out_illegal_d;

    logic [3:0]      dec_ctrl_c;
    logic [XLEN-1:0] dec_a_c, dec_b_c;
    logic            dec_illegal_c, dec_br_c, dec_br_zero_c, dec_br_inv_c;
    logic            br_cond_c;

    // Instruction decode: ALU code, operand selection and legality.
    always_comb begin
        dec_ctrl_c    = ALU_ADD;
        dec_a_c       = rs1_val;
        dec_b_c       = rs2_val;
        dec_illegal_c = 1'b0;
        dec_br_c      = 1'b0;
        dec_br_zero_c = 1'b0;
        dec_br_inv_c  = 1'b0;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                if (opcode == OPC_OP_IMM) dec_b_c = imm;
                case (funct3)
                    3'b000: dec_ctrl_c = (opcode == OPC_OP && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001: begin
                        dec_ctrl_c    = ALU_SLL;
                        dec_illegal_c = (opcode == OPC_OP_IMM) && funct7_5;
                    end
                    3'b010: dec_ctrl_c = ALU_SLT;
                    3'b011: dec_ctrl_c = ALU_SLTU;
                    3'b100: dec_ctrl_c = ALU_XOR;
                    3'b101: dec_ctrl_c = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110: dec_ctrl_c = ALU_OR;
                    default: dec_ctrl_c = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                dec_a_c = '0;
                dec_b_c = imm;
            end
            OPC_AUIPC: begin
                dec_a_c = pc;
                dec_b_c = imm;
            end
            OPC_BRANCH: begin
                dec_br_c     = 1'b1;
                dec_br_inv_c = funct3[0];
                case (funct3[2:1])
                    2'b00: begin
                        dec_ctrl_c    = ALU_SUB;
                        dec_br_zero_c = 1'b1;
                    end
                    2'b10:   dec_ctrl_c = ALU_SLT;
                    2'b11:   dec_ctrl_c = ALU_SLTU;
                    default: dec_illegal_c = 1'b1;
                endcase
            end
            default: dec_illegal_c = 1'b1;
        endcase
    end

    assign br_cond_c = (br_zero_q ? alu_is_zero : alu_out[0]) ^ br_inv_q;

    // Next-state and output-register logic.
    always_comb begin
        state_d         = state_q;
        alu_a_d         = alu_a_q;
        alu_b_d         = alu_b_q;
        alu_ctrl_d      = alu_ctrl_q;
        br_d            = br_q;
        br_zero_d       = br_zero_q;
        br_inv_d        = br_inv_q;
        out_result_d    = out_result_q;
        out_is_branch_d = out_is_branch_q;
        out_taken_d     = out_taken_q;
        out_illegal_d   = out_illegal_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (dec_illegal_c) begin
                        // Illegal: skip EXEC, ALU inputs keep their last values.
                        state_d         = DONE;
                        out_result_d    = '0;
                        out_is_branch_d = 1'b0;
                        out_taken_d     = 1'b0;
                        out_illegal_d   = 1'b1;
                    end else begin
                        state_d    = EXEC;
                        alu_a_d    = dec_a_c;
                        alu_b_d    = dec_b_c;
                        alu_ctrl_d = dec_ctrl_c;
                        br_d       = dec_br_c;
                        br_zero_d  = dec_br_zero_c;
                        br_inv_d   = dec_br_inv_c;
                    end
                end
            end
            EXEC: begin
                state_d         = DONE;
                out_result_d    = alu_out;
                out_is_branch_d = br_q;
                out_taken_d     = br_q && br_cond_c;
                out_illegal_d   = 1'b0;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            alu_a_q         <= '0;
            alu_b_q         <= '0;
            alu_ctrl_q      <= ALU_AND;
            br_q            <= 1'b0;
            br_zero_q       <= 1'b0;
            br_inv_q        <= 1'b0;
            out_valid_q     <= 1'b0;
            out_result_q    <= '0;
            out_is_branch_q <= 1'b0;
            out_taken_q     <= 1'b0;
            out_illegal_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            alu_a_q         <= alu_a_d;
            alu_b_q         <= alu_b_d;
            alu_ctrl_q      <= alu_ctrl_d;
            br_q            <= br_d;
            br_zero_q       <= br_zero_d;
            br_inv_q        <= br_inv_d;
            out_valid_q     <= out_valid_d;
            out_result_q    <= out_result_d;
            out_is_branch_q <= out_is_branch_d;
            out_taken_q     <= out_taken_d;
            out_illegal_q   <= out_illegal_d;
        end
    end

    // in_ready is a pure state decode so upstream sees it without a cycle of lag.
    assign in_ready         = (state_q == IDLE);
    assign alu_a            = alu_a_q;
    assign alu_b            = alu_b_q;
    assign alu_ctrl         = alu_ctrl_q;
    assign out_valid        = out_valid_q;
    assign out_result       = out_result_q;
    assign out_is_branch    = out_is_branch_q;
    assign out_branch_taken = out_taken_q;
    assign out_illegal      = out_illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue with a behavioural ALU attached.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] rs1_val, rs2_val, imm, pc;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_out;
    logic        alu_is_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_is_branch;
    logic        out_branch_taken;
    logic        out_illegal;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] BRANCH = 7'b1100011;

    always #5 clk = ~clk;

    alu_issue #(.XLEN(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .opcode           (opcode),
        .funct3           (funct3),
        .funct7_5         (funct7_5),
        .rs1_val          (rs1_val),
        .rs2_val          (rs2_val),
        .imm              (imm),
        .pc               (pc),
        .alu_a            (alu_a),
        .alu_b            (alu_b),
        .alu_ctrl         (alu_ctrl),
        .alu_out          (alu_out),
        .alu_is_zero      (alu_is_zero),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_result       (out_result),
        .out_is_branch    (out_is_branch),
        .out_branch_taken (out_branch_taken),
        .out_illegal      (out_illegal)
    );

    // Behavioural RV32I ALU.
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_out = alu_a & alu_b;
            4'b0001: alu_out = alu_a | alu_b;
            4'b0010: alu_out = alu_a ^ alu_b;
            4'b0100: alu_out = alu_a + alu_b;
            4'b0101: alu_out = alu_a - alu_b;
            4'b0110: alu_out = alu_a << alu_b[4:0];
            4'b0111: alu_out = alu_a >> alu_b[4:0];
            4'b1000: alu_out = 32'($signed(alu_a) >>> alu_b[4:0]);
            4'b1001: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'b1010: alu_out = {31'd0, alu_a < alu_b};
            default: alu_out = 32'd0;
        endcase
        alu_is_zero = (alu_out == 32'd0);
    end

    // Present one instruction; lat = rising edges from the accept edge
    // (inclusive) until out_valid is seen, capped at 10.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] im, input logic [31:0] p,
                         output int lat, output logic [3:0] ctrl_seen);
        opcode = op; funct3 = f3; funct7_5 = f7;
        rs1_val = r1; rs2_val = r2; imm = im; pc = p;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ctrl_seen = alu_ctrl;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin n_err++; $display("FAIL reset_alu_ab got %h/%h want 0/0", alu_a, alu_b); end
        n_cmp++; if (alu_ctrl !== 4'b0000) begin n_err++; $display("FAIL reset_alu_ctrl got %b want 0000", alu_ctrl); end
        n_cmp++; if ({out_result, out_is_branch, out_branch_taken, out_illegal} !== 35'd0) begin
            n_err++; $display("FAIL reset_out_fields got %h %b%b%b want 0", out_result, out_is_branch, out_branch_taken, out_illegal);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int lat; logic [3:0] c;
        issue(OP, 3'b000, 1'b0, 32'd4, 32'd8, 32'd0, 32'd0, lat, c);
        n_cmp++; if (c !== 4'b0100) begin n_err++; $display("FAIL add_ctrl got %b want 0100", c); end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL add_latency got %0d want 2", lat); end
        n_cmp++; if (out_result !== 32'h0000000C) begin n_err++; $display("FAIL add_result got %h want 0000000c", out_result); end
        n_cmp++; if (out_illegal !== 1'b0 || out_is_branch !== 1'b0) begin n_err++; $display("FAIL add_flags got ill=%b br=%b want 0/0", out_illegal, out_is_branch); end
        n_cmp++; if (alu_a !== 32'd4 || alu_b !== 32'd8) begin n_err++; $display("FAIL add_operands got %h/%h want 4/8", alu_a, alu_b); end
        release_out();
    endtask

    task automatic test_sub_branch();
        int lat; logic [3:0] c;
        issue(OP, 3'b000, 1'b1, 32'h0000FFFF, 32'h0000FFFF, 32'd0, 32'd0, lat, c);
        n_cmp++; if (c !== 4'b0101) begin n_err++; $display("FAIL sub_ctrl got %b want 0101", c); end
        n_cmp++; if (out_result !== 32'd0) begin n_err++; $display("FAIL sub_result got %h want 0", out_result); end
        release_out();
        issue(BRANCH, 3'b000, 1'b0, 32'h0000FFFF, 32'h0000FFFF, 32'd0, 32'd0, lat, c);
        n_cmp++; if (c !== 4'b0101) begin n_err++; $display("FAIL beq_ctrl got %b want 0101", c); end
        n_cmp++; if (out_is_branch !== 1'b1 || out_branch_taken !== 1'b1) begin n_err++; $display("FAIL beq_taken got br=%b tk=%b want 1/1", out_is_branch, out_branch_taken); end
        release_out();
        issue(BRANCH, 3'b001, 1'b0, 32'h0000FFFF, 32'h0000FFFF, 32'd0, 32'd0, lat, c);
        n_cmp++; if (out_is_branch !== 1'b1 || out_branch_taken !== 1'b0) begin n_err++; $display("FAIL bne_taken got br=%b tk=%b want 1/0", out_is_branch, out_branch_taken); end
        release_out();
    endtask

    task automatic test_blt();
        int lat; logic [3:0] c;
        issue(BRANCH, 3'b100, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, lat, c);
        n_cmp++; if (c !== 4'b1001) begin n_err++; $display("FAIL blt_ctrl got %b want 1001", c); end
        n_cmp++; if (out_branch_taken !== 1'b1 || out_result !== 32'd1) begin n_err++; $display("FAIL blt_taken got tk=%b res=%h want 1/1", out_branch_taken, out_result); end
        release_out();
        issue(BRANCH, 3'b110, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, lat, c);
        n_cmp++; if (c !== 4'b1010) begin n_err++; $display("FAIL bltu_ctrl got %b want 1010", c); end
        n_cmp++; if (out_branch_taken !== 1'b0 || out_result !== 32'd0) begin n_err++; $display("FAIL bltu_taken got tk=%b res=%h want 0/0", out_branch_taken, out_result); end
        release_out();
        issue(BRANCH, 3'b111, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, lat, c);
        n_cmp++; if (out_branch_taken !== 1'b1) begin n_err++; $display("FAIL bgeu_taken got %b want 1", out_branch_taken); end
        release_out();
    endtask

    task automatic test_srai();
        int lat; logic [3:0] c;
        issue(OP_IMM, 3'b101, 1'b1, 32'h80000000, 32'h0, 32'h00000401, 32'd0, lat, c);
        n_cmp++; if (c !== 4'b1000) begin n_err++; $display("FAIL srai_ctrl got %b want 1000", c); end
        n_cmp++; if (out_result !== 32'hC0000000) begin n_err++; $display("FAIL srai_result got %h want c0000000", out_result); end
        release_out();
    endtask

    task automatic test_lui_auipc();
        int lat; logic [3:0] c;
        issue(LUI, 3'b000, 1'b0, 32'hDEADBEEF, 32'h0, 32'h12345000, 32'h40, lat, c);
        n_cmp++; if (out_result !== 32'h12345000 || alu_a !== 32'd0) begin n_err++; $display("FAIL lui_result got %h a=%h want 12345000 a=0", out_result, alu_a); end
        release_out();
        issue(AUIPC, 3'b000, 1'b0, 32'hDEADBEEF, 32'h0, 32'h00001000, 32'h100, lat, c);
        n_cmp++; if (out_result !== 32'h00001100) begin n_err++; $display("FAIL auipc_result got %h want 00001100", out_result); end
        release_out();
    endtask

    task automatic test_illegal();
        int lat; logic [3:0] c;
        issue(7'h7F, 3'b000, 1'b0, 32'd1, 32'd2, 32'd3, 32'd4, lat, c);
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL illegal_latency got %0d want 1", lat); end
        n_cmp++; if (out_illegal !== 1'b1 || out_result !== 32'd0) begin n_err++; $display("FAIL illegal_flags got ill=%b res=%h want 1/0", out_illegal, out_result); end
        n_cmp++; if (c !== 4'b0100 || alu_a !== 32'h100) begin n_err++; $display("FAIL illegal_alu_held got ctrl=%b a=%h want 0100/100", c, alu_a); end
        release_out();
        issue(OP_IMM, 3'b001, 1'b1, 32'd1, 32'd0, 32'h401, 32'd0, lat, c);
        n_cmp++; if (out_illegal !== 1'b1 || lat !== 1) begin n_err++; $display("FAIL slli_f7_illegal got ill=%b lat=%0d want 1/1", out_illegal, lat); end
        release_out();
        issue(BRANCH, 3'b010, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, lat, c);
        n_cmp++; if (out_illegal !== 1'b1 || out_is_branch !== 1'b0) begin n_err++; $display("FAIL branch_f3_010 got ill=%b br=%b want 1/0", out_illegal, out_is_branch); end
        release_out();
        issue(OP, 3'b111, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, lat, c);
        n_cmp++; if (out_illegal !== 1'b0 || out_result !== 32'h00F0) begin n_err++; $display("FAIL and_after_illegal got ill=%b res=%h want 0/000000f0", out_illegal, out_result); end
        release_out();
    endtask

    task automatic test_hold();
        int lat; logic [3:0] c;
        issue(OP, 3'b000, 1'b0, 32'd3, 32'd5, 32'd0, 32'd0, lat, c);
        // Present another instruction while DONE is stalled; it must be ignored.
        opcode = OP; funct3 = 3'b110; funct7_5 = 1'b0; rs1_val = 32'd1; rs2_val = 32'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 32'd8 ||
                out_illegal !== 1'b0 || alu_ctrl !== 4'b0100) begin
                n_err++;
                $display("FAIL hold_cycle%0d got v=%b rdy=%b res=%h ill=%b ctrl=%b want 1/0/8/0/0100",
                         i, out_valid, in_ready, out_result, out_illegal, alu_ctrl);
            end
        end
        in_valid = 1'b0;
        release_out();
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL hold_release got rdy=%b v=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        int valids  = 0;
        opcode = OP; funct3 = 3'b000; funct7_5 = 1'b0; rs1_val = 32'd1; rs2_val = 32'd2;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (in_ready === 1'b1) accepts++;
            if (out_valid === 1'b1) valids++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++; if (accepts !== 3) begin n_err++; $display("FAIL b2b_accepts got %0d want 3", accepts); end
        n_cmp++; if (valids !== 3 || out_result !== 32'd3) begin n_err++; $display("FAIL b2b_results got v=%0d res=%h want 3/3", valids, out_result); end
    endtask

    task automatic test_reset_exec();
        int lat; logic [3:0] c;
        opcode = OP; funct3 = 3'b000; funct7_5 = 1'b0; rs1_val = 32'd10; rs2_val = 32'd20;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || alu_a !== 32'd10) begin n_err++; $display("FAIL exec_state got rdy=%b v=%b a=%h want 0/0/a", in_ready, out_valid, alu_a); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rst_exec_hs got v=%b rdy=%b want 0/1", out_valid, in_ready); end
        n_cmp++; if (alu_a !== 32'd0 || alu_ctrl !== 4'b0000 || out_result !== 32'd0) begin n_err++; $display("FAIL rst_exec_regs got a=%h ctrl=%b res=%h want 0", alu_a, alu_ctrl, out_result); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(OP, 3'b100, 1'b0, 32'hFF00, 32'h0F0F, 32'd0, 32'd0, lat, c);
        n_cmp++; if (out_result !== 32'h0000F00F || lat !== 2) begin n_err++; $display("FAIL post_reset_xor got res=%h lat=%0d want 0000f00f/2", out_result, lat); end
        release_out();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; funct3 = '0; funct7_5 = 1'b0;
        rs1_val = '0; rs2_val = '0; imm = '0; pc = '0;
        test_reset();
        test_add();
        test_sub_branch();
        test_blt();
        test_srai();
        test_lui_auipc();
        test_illegal();
        test_hold();
        test_back_to_back();
        test_reset_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
